dlx_mailbox: RTL and testbench
==============================

Name: dlx_mailbox

Overview:
- Memory-mapped responder on the dlx_processor data bus: same rd_ena/wr_ena/address/wr_data/rd_data signalling and 1-cycle read latency as sp_ram.
- Gives the CPU two FIFOs. The CPU writes a TX FIFO drained by an external valid/ready stream, and pops an RX FIFO filled by an external stream.
- Sits beside sp_ram. The top level decodes the chip-select and gates rd_ena/wr_ena.

Parameters:
- DATA_WIDTH, 32, data bus and FIFO word width (≥24).
- DEPTH_LOG2, 3, log2 of each FIFO depth (8 entries); legal 1..7.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_ena  in  1  bus read strobe.
- wr_ena  in  1  bus write strobe.
- address  in  2  word offset within the mailbox (byte address [3:2]).
- wr_data  in  DATA_WIDTH  bus write data.
- rd_data  out  DATA_WIDTH  bus read data, registered.
- tx_data  out  DATA_WIDTH  TX FIFO head (first-word fall-through).
- tx_valid  out  1  TX FIFO non-empty.
- tx_ready  in  1  external sink accepts tx_data.
- rx_data  in  DATA_WIDTH  external word into RX FIFO.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  RX FIFO not full.

Behaviour:
- Reset: both FIFOs empty, counts 0, sticky flags 0, rd_data=0, tx_valid=0, rx_ready=1. Reset mid-transfer discards all contents; same cycle priority over every other event.
- Register map (address):
  - 0 TXDATA: write pushes wr_data; read returns 0.
  - 1 RXDATA: read pops and returns the head; write ignored.
  - 2 STATUS, read-only:
    - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty.
    - bit4 tx_overflow, bit5 rx_underflow (sticky).
    - [15:8] tx_count, [23:16] rx_count (zero-extended); other bits 0.
  - 3 CTRL: write-only, read returns 0; bits are pulses, not stored.
    - bit0 flush TX; bit1 flush RX.
    - bit2 clear tx_overflow; bit3 clear rx_underflow.
- Read latency: rd_data updates on the edge after rd_ena=1 and holds its value while rd_ena=0. STATUS reports state before that cycle's updates.
- rd_ena and wr_ena asserted in the same cycle: both are serviced (write effect plus read).
- TX push when tx_full (start-of-cycle): word dropped, tx_overflow set. This applies even if the stream pops in the same cycle.
- TX stream pop: when tx_valid & tx_ready.
- RXDATA read when rx_empty: returns 0, no pop, rx_underflow set.
- RX push: when rx_valid & rx_ready. rx_ready is a registered-state function (!rx_full), so rx_valid while full is simply not accepted, with no flag.
- Simultaneous push and pop on one FIFO that is neither full nor empty: count unchanged, data order preserved.
- Flush: count←0, pointers←0 at the edge. It overrides a push or pop in the same cycle (including a CPU write to TXDATA of that cycle).
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Counts are DEPTH_LOG2+1 bits; full = count==2**DEPTH_LOG2.
- No combinational path from bus inputs to rd_data. tx_valid and rx_ready depend only on registered state.

Decomposition:
- Package dlx_mailbox_pkg:
  - register offset constants MBOX_TXDATA=0, MBOX_RXDATA=1, MBOX_STATUS=2, MBOX_CTRL=3;
  - STATUS and CTRL bit-index constants.
- Sub-module sync_fifo (DATA_WIDTH, DEPTH_LOG2; push, pop, flush, rd head, full, empty, count), instantiated twice. Top is decode, sticky flags and rd_data register.

Test Plan:
- Reset, then read STATUS → rd_data = 0x0000_000A (tx_empty, rx_empty) one cycle after rd_ena.
- tx_ready=0; write 0x11..0x18 to TXDATA → STATUS tx_count=8, tx_full=1. A 9th write of 0x99 sets bit4. Raise tx_ready → tx_data emits 0x11..0x18 in order, 0x99 never appears.
- Drive rx_valid with 0xA0..0xA8 → rx_ready drops after 8 accepted. Reading RXDATA 8 times returns 0xA0..0xA7. A 9th read returns 0 and sets bit5.
- tx_ready=1 continuously while the CPU writes every cycle → tx_count stays ≤1, no overflow; order preserved across pointer wrap (20 words).
- Fill TX with 4 words, write CTRL=0x1 → STATUS next read tx_count=0, tx_valid=0. Write CTRL=0xC → bits4/5 cleared.
- Assert rst for 1 cycle with both FIFOs half full and rd_ena high → next cycle rd_data=0, tx_valid=0, rx_ready=1, counts 0.

Source files
------------

// File: rtl/dlx_mailbox_pkg.sv
// Register map, STATUS/CTRL bit positions and STATUS packing for the dlx_mailbox bus responder.
package dlx_mailbox_pkg;

  localparam logic [1:0] MBOX_TXDATA = 2'd0;
  localparam logic [1:0] MBOX_RXDATA = 2'd1;
  localparam logic [1:0] MBOX_STATUS = 2'd2;
  localparam logic [1:0] MBOX_CTRL   = 2'd3;

  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_FULL  = 2;
  localparam int STAT_RX_EMPTY = 3;
  localparam int STAT_TX_OVF   = 4;
  localparam int STAT_RX_UNF   = 5;
  localparam int STAT_TX_CNT   = 8;
  localparam int STAT_RX_CNT   = 16;

  localparam int CTRL_FLUSH_TX = 0;
  localparam int CTRL_FLUSH_RX = 1;
  localparam int CTRL_CLR_OVF  = 2;
  localparam int CTRL_CLR_UNF  = 3;

  function automatic logic [23:0] mbox_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty,
    input logic       tx_ovf,
    input logic       rx_unf,
    input logic [7:0] tx_cnt,
    input logic [7:0] rx_cnt
  );
    logic [23:0] s;
    s = '0;
    s[STAT_TX_FULL]  = tx_full;
    s[STAT_TX_EMPTY] = tx_empty;
    s[STAT_RX_FULL]  = rx_full;
    s[STAT_RX_EMPTY] = rx_empty;
    s[STAT_TX_OVF]   = tx_ovf;
    s[STAT_RX_UNF]   = rx_unf;
    s[STAT_TX_CNT +: 8] = tx_cnt;
    s[STAT_RX_CNT +: 8] = rx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/dlx_mailbox_fifo.sv
// First-word-fall-through synchronous FIFO; push while full and pop while empty are ignored.
// Flush clears pointers and count and overrides any push/pop of the same cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: reads are qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dlx_mailbox.sv
// CPU mailbox on the dlx data bus: TX FIFO drained by a valid/ready stream, RX FIFO filled by one.
// Bus decode, sticky error flags and the registered 1-cycle read path live here.
module dlx_mailbox
  import dlx_mailbox_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_ena,
  input  logic                  wr_ena,
  input  logic [1:0]            address,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);

  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic [DEPTH_LOG2:0]   tx_count, rx_count;
  logic [DATA_WIDTH-1:0] rx_head;
  logic                  tx_ovf, rx_unf;
  logic                  tx_wr, ctrl_wr, rx_rd;
  logic                  tx_flush, rx_flush;
  logic [23:0]           status;

  assign tx_wr    = wr_ena && (address == MBOX_TXDATA);
  assign ctrl_wr  = wr_ena && (address == MBOX_CTRL);
  assign rx_rd    = rd_ena && (address == MBOX_RXDATA);
  assign tx_flush = ctrl_wr && wr_data[CTRL_FLUSH_TX];
  assign rx_flush = ctrl_wr && wr_data[CTRL_FLUSH_RX];

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_wr),
    .push_data (wr_data),
    .pop       (tx_ready),
    .flush     (tx_flush),
    .head      (tx_data),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_rd),
    .flush     (rx_flush),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  assign status = mbox_status(tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_unf,
                              8'(tx_count), 8'(rx_count));

  // Set and clear come from different addresses, so they never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      if (tx_wr && tx_full)
        tx_ovf <= 1'b1;
      else if (ctrl_wr && wr_data[CTRL_CLR_OVF])
        tx_ovf <= 1'b0;
      if (rx_rd && rx_empty)
        rx_unf <= 1'b1;
      else if (ctrl_wr && wr_data[CTRL_CLR_UNF])
        rx_unf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_ena) begin
      unique case (address)
        MBOX_RXDATA: rd_data <= rx_empty ? '0 : rx_head;
        MBOX_STATUS: rd_data <= DATA_WIDTH'(status);
        default:     rd_data <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dlx_mailbox.sv
// Directed bench for dlx_mailbox: expected bus reads and TX stream words are queued by the
// stimulus and consumed by independent monitors.
module tb_dlx_mailbox;
  import dlx_mailbox_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_ena = 1'b0, wr_ena = 1'b0;
  logic [1:0]  address = 2'd0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data, tx_data;
  logic        tx_valid, rx_ready;
  logic        tx_ready = 1'b0;
  logic [31:0] rx_data = '0;
  logic        rx_valid = 1'b0;

  int total = 0;
  int bad   = 0;
  logic [31:0] rd_q [$];
  logic [31:0] tx_q [$];
  logic        rd_pend = 1'b0;

  dlx_mailbox #(.DATA_WIDTH(32), .DEPTH_LOG2(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_ena   (rd_ena),
    .wr_ena   (wr_ena),
    .address  (address),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    wr_ena = 1'b1; address = a; wr_data = d;
    tick();
    wr_ena = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp);
    rd_ena = 1'b1; address = a;
    rd_q.push_back(exp);
    tick();
    rd_ena = 1'b0;
  endtask

  // Bus read monitor: rd_data is due one edge after the cycle carrying rd_ena.
  always @(negedge clk) begin
    if (rd_pend) begin
      if (rd_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected: got 0x%08h with no expected value queued", rd_data);
      end else begin
        chk("rd_data", rd_data, rd_q.pop_front());
      end
    end
    rd_pend = rd_ena;
  end

  // TX stream monitor: a transfer occurs on the coming edge when valid & ready.
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) begin
        total++; bad++;
        $display("FAIL tx_unexpected: got 0x%08h with no expected word queued", tx_data);
      end else begin
        chk("tx_data", tx_data, tx_q.pop_front());
      end
    end
  end

  initial begin
    int k;
    logic acc;

    repeat (2) tick();
    rst = 1'b0;
    chk("reset tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset rx_ready", {31'd0, rx_ready}, 32'd1);
    bus_read(MBOX_STATUS, 32'h0000_000A);

    // Fill TX to full, then overflow once.
    for (int i = 0; i < 8; i++) bus_write(MBOX_TXDATA, 32'h11 + i);
    bus_read(MBOX_STATUS, 32'h0000_0809);
    bus_write(MBOX_TXDATA, 32'h99);
    bus_read(MBOX_STATUS, 32'h0000_0819);
    bus_read(MBOX_TXDATA, 32'h0);
    bus_read(MBOX_CTRL, 32'h0);
    for (int i = 0; i < 8; i++) tx_q.push_back(32'h11 + i);
    tx_ready = 1'b1;
    repeat (10) tick();
    tx_ready = 1'b0;
    bus_read(MBOX_STATUS, 32'h0000_001A);

    // Fill RX from the stream until it refuses.
    k = 0;
    for (int i = 0; i < 12; i++) begin
      rx_data = 32'hA0 + k; rx_valid = 1'b1;
      acc = rx_ready;
      tick();
      if (acc) k++;
    end
    rx_valid = 1'b0;
    chk("rx accepted", k, 32'd8);
    chk("rx_ready full", {31'd0, rx_ready}, 32'd0);
    bus_read(MBOX_STATUS, 32'h0008_0016);
    for (int i = 0; i < 8; i++) bus_read(MBOX_RXDATA, 32'hA0 + i);
    bus_read(MBOX_RXDATA, 32'h0);
    bus_read(MBOX_STATUS, 32'h0000_003A);

    // Clear sticky flags, then stream 20 words through with back-to-back writes.
    bus_write(MBOX_CTRL, 32'hC);
    bus_read(MBOX_STATUS, 32'h0000_000A);
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_q.push_back(32'h100 + i);
      bus_write(MBOX_TXDATA, 32'h100 + i);
      chk("stream tx_valid", {31'd0, tx_valid}, 32'd1);
    end
    repeat (2) tick();
    tx_ready = 1'b0;
    bus_read(MBOX_STATUS, 32'h0000_000A);

    // Flush TX with a simultaneous CTRL read.
    for (int i = 0; i < 4; i++) bus_write(MBOX_TXDATA, 32'h200 + i);
    bus_read(MBOX_STATUS, 32'h0000_0408);
    rd_ena = 1'b1; wr_ena = 1'b1; address = MBOX_CTRL; wr_data = 32'h1;
    rd_q.push_back(32'h0);
    tick();
    rd_ena = 1'b0; wr_ena = 1'b0;
    chk("flush tx_valid", {31'd0, tx_valid}, 32'd0);
    bus_read(MBOX_STATUS, 32'h0000_000A);

    // Raise both sticky flags, then clear them together.
    bus_read(MBOX_RXDATA, 32'h0);
    for (int i = 0; i < 9; i++) bus_write(MBOX_TXDATA, 32'h300 + i);
    bus_read(MBOX_STATUS, 32'h0000_0839);
    bus_write(MBOX_CTRL, 32'hC);
    bus_read(MBOX_STATUS, 32'h0000_0809);
    bus_write(MBOX_CTRL, 32'h1);
    bus_read(MBOX_STATUS, 32'h0000_000A);

    // Reset with both FIFOs half full and a read in flight.
    for (int i = 0; i < 4; i++) bus_write(MBOX_TXDATA, 32'h400 + i);
    for (int i = 0; i < 4; i++) begin
      rx_data = 32'h500 + i; rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    bus_read(MBOX_STATUS, 32'h0004_0400);
    rst = 1'b1; rd_ena = 1'b1; address = MBOX_STATUS;
    rd_q.push_back(32'h0);
    tick();
    rst = 1'b0; rd_ena = 1'b0;
    chk("rst tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst rx_ready", {31'd0, rx_ready}, 32'd1);
    bus_read(MBOX_STATUS, 32'h0000_000A);

    repeat (3) tick();
    chk("rd queue drained", rd_q.size(), 32'd0);
    chk("tx queue drained", tx_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
